// File: rtl/bus_pkg.sv
// Shared bus constants and the arbiter state encoding, imported by the
// arbiter, the address decoder and the peripherals.
package bus_pkg;

  localparam int BUS_W       = 32;
  localparam int BUS_AW      = 16;
  localparam int TMO_DEFAULT = 15;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_ISSUE = 2'd1,
    ST_RD_WAIT  = 2'd2
  } bus_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, and on a tie the master
// that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant
);

  always_comb begin
    grant = 1'b0;
    if (req == 2'b11) grant = ~last;
    else              grant = req[1];
  end

endmodule

// File: rtl/bus_arb.sv
// Two-master arbiter for the shared peripheral bus: serialises reads and writes
// with round-robin fairness and force-completes reads the decoder never answers.
//
// Handshake: a master raises ren or wen and holds the request (with addr, wdata
// and wmask stable) until the matching rd_valid or the one-cycle wack; a read
// completes in the cycle rd_valid is high. ren together with wen is a read.
module bus_arb
  import bus_pkg::*;
#(
  parameter int W   = BUS_W,
  parameter int AW  = BUS_AW,
  parameter int TMO = TMO_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic          m0_ren,
  input  logic          m1_ren,
  input  logic          m0_wen,
  input  logic          m1_wen,
  input  logic [W-1:0]  m0_wdata,
  input  logic [W-1:0]  m1_wdata,
  input  logic [3:0]    m0_wmask,
  input  logic [3:0]    m1_wmask,
  output logic [W-1:0]  m0_rdata,
  output logic [W-1:0]  m1_rdata,
  output logic          m0_rd_valid,
  output logic          m1_rd_valid,
  output logic          m0_wack,
  output logic          m1_wack,
  output logic [AW-1:0] s_addr,
  output logic          s_ren,
  output logic          s_wen,
  output logic [W-1:0]  s_wdata,
  output logic [3:0]    s_wmask,
  input  logic [W-1:0]  s_rdata,
  input  logic          s_rd_valid,
  output logic          owner,
  output logic          bus_err,
  output bus_state_e    dbg_state
);

  bus_state_e state;
  logic       last;
  logic [7:0] cnt;
  logic [1:0] req;
  logic       win;
  logic       win_ren;
  logic       rd_wait;
  logic       tmo_hit;
  logic       rd_done;

  assign req = {m1_ren | m1_wen, m0_ren | m0_wen};

  rr_arb2 u_rr (
    .req   (req),
    .last  (last),
    .grant (win)
  );

  assign win_ren = win ? m1_ren : m0_ren;

  // A real completion on the timeout cycle wins over the forced one.
  assign rd_wait = (state == ST_RD_WAIT);
  assign tmo_hit = rd_wait && !s_rd_valid && (cnt == 8'(TMO));
  assign rd_done = rd_wait && (s_rd_valid || tmo_hit);

  assign m0_rd_valid = rd_done && !owner;
  assign m1_rd_valid = rd_done && owner;
  assign m0_rdata    = (rd_wait && !tmo_hit) ? s_rdata : '0;
  assign m1_rdata    = (rd_wait && !tmo_hit) ? s_rdata : '0;
  assign m0_wack     = s_wen && !owner;
  assign m1_wack     = s_wen && owner;
  assign bus_err     = tmo_hit;
  assign dbg_state   = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      s_addr  <= '0;
      s_wdata <= '0;
      s_wmask <= '0;
      s_ren   <= 1'b0;
      s_wen   <= 1'b0;
      owner   <= 1'b0;
      last    <= 1'b1;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req) begin
            s_addr  <= win ? m1_addr  : m0_addr;
            s_wdata <= win ? m1_wdata : m0_wdata;
            s_wmask <= win ? m1_wmask : m0_wmask;
            owner   <= win;
            last    <= win;
            cnt     <= '0;
            if (win_ren) begin
              s_ren <= 1'b1;
              state <= ST_RD_WAIT;
            end else begin
              s_wen <= 1'b1;
              state <= ST_WR_ISSUE;
            end
          end
        end
        ST_WR_ISSUE: begin
          s_wen <= 1'b0;
          state <= ST_IDLE;
        end
        ST_RD_WAIT: begin
          if (rd_done) begin
            s_ren <= 1'b0;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          s_ren <= 1'b0;
          s_wen <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arb.sv
// Directed bench for bus_arb: lone read, tied writes, round-robin reads,
// read timeout, reset during a read and read/write conflict.
module tb_bus_arb;
  import bus_pkg::*;

  localparam int W   = 32;
  localparam int AW  = 16;
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_addr, m1_addr;
  logic          m0_ren, m1_ren, m0_wen, m1_wen;
  logic [W-1:0]  m0_wdata, m1_wdata;
  logic [3:0]    m0_wmask, m1_wmask;
  logic [W-1:0]  m0_rdata, m1_rdata;
  logic          m0_rd_valid, m1_rd_valid, m0_wack, m1_wack;
  logic [AW-1:0] s_addr;
  logic          s_ren, s_wen;
  logic [W-1:0]  s_wdata;
  logic [3:0]    s_wmask;
  logic [W-1:0]  s_rdata;
  logic          s_rd_valid;
  logic          owner, bus_err;
  bus_state_e    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bus_arb #(.W(W), .AW(AW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_ren(m0_ren), .m1_ren(m1_ren), .m0_wen(m0_wen), .m1_wen(m1_wen),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_wmask(m0_wmask), .m1_wmask(m1_wmask),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .m0_rd_valid(m0_rd_valid), .m1_rd_valid(m1_rd_valid),
    .m0_wack(m0_wack), .m1_wack(m1_wack),
    .s_addr(s_addr), .s_ren(s_ren), .s_wen(s_wen),
    .s_wdata(s_wdata), .s_wmask(s_wmask),
    .s_rdata(s_rdata), .s_rd_valid(s_rd_valid),
    .owner(owner), .bus_err(bus_err), .dbg_state(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    m0_addr = '0; m1_addr = '0;
    m0_ren = 0; m1_ren = 0; m0_wen = 0; m1_wen = 0;
    m0_wdata = '0; m1_wdata = '0; m0_wmask = '0; m1_wmask = '0;
    s_rdata = '0; s_rd_valid = 0;

    // Reset state
    do_reset();
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_s_ren", 32'(s_ren), 0);
    chk("rst_s_wen", 32'(s_wen), 0);
    chk("rst_s_addr", 32'(s_addr), 0);
    chk("rst_owner", 32'(owner), 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    chk("rst_rdv", {30'd0, m1_rd_valid, m0_rd_valid}, 0);
    chk("rst_wack", {30'd0, m1_wack, m0_wack}, 0);
    chk("rst_rdata", m0_rdata, 0);

    // Lone read from m0 with a 1-cycle slave
    m0_addr = 16'h0010; m0_ren = 1;
    tick();
    chk("lr_s_ren", 32'(s_ren), 1);
    chk("lr_s_addr", 32'(s_addr), 32'h0010);
    chk("lr_owner", 32'(owner), 0);
    chk("lr_state", 32'(dbg_state), 32'(ST_RD_WAIT));
    s_rd_valid = 1; s_rdata = 32'hDEADBEEF;
    #1;
    chk("lr_m0_rdv", 32'(m0_rd_valid), 1);
    chk("lr_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("lr_m1_rdv", 32'(m1_rd_valid), 0);
    chk("lr_m1_wack", 32'(m1_wack), 0);
    m0_ren = 0;
    tick();
    s_rd_valid = 0; s_rdata = '0;
    #1;
    chk("lr_s_ren_drop", 32'(s_ren), 0);
    chk("lr_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("lr_rdv_drop", 32'(m0_rd_valid), 0);

    // s_rd_valid while idle must not reach a master
    s_rd_valid = 1;
    #1;
    chk("idle_rdv_ign", {30'd0, m1_rd_valid, m0_rd_valid}, 0);
    s_rd_valid = 0;

    // Simultaneous writes straight after reset: m0 first, then m1
    do_reset();
    m0_addr = 16'h0100; m0_wdata = 32'hAAAA5555; m0_wmask = 4'hF; m0_wen = 1;
    m1_addr = 16'h0200; m1_wdata = 32'h12345678; m1_wmask = 4'h3; m1_wen = 1;
    tick();
    chk("wr0_s_wen", 32'(s_wen), 1);
    chk("wr0_owner", 32'(owner), 0);
    chk("wr0_m0_wack", 32'(m0_wack), 1);
    chk("wr0_m1_wack", 32'(m1_wack), 0);
    chk("wr0_wdata", s_wdata, 32'hAAAA5555);
    chk("wr0_wmask", 32'(s_wmask), 32'hF);
    chk("wr0_addr", 32'(s_addr), 32'h0100);
    chk("wr0_state", 32'(dbg_state), 32'(ST_WR_ISSUE));
    m0_wen = 0;
    tick();
    chk("wr0_s_wen_drop", 32'(s_wen), 0);
    chk("wr0_wack_drop", {30'd0, m1_wack, m0_wack}, 0);
    chk("wr0_idle", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    chk("wr1_s_wen", 32'(s_wen), 1);
    chk("wr1_owner", 32'(owner), 1);
    chk("wr1_m1_wack", 32'(m1_wack), 1);
    chk("wr1_m0_wack", 32'(m0_wack), 0);
    chk("wr1_wdata", s_wdata, 32'h12345678);
    chk("wr1_wmask", 32'(s_wmask), 32'h3);
    m1_wen = 0;
    tick();
    chk("wr1_s_wen_drop", 32'(s_wen), 0);

    // Round-robin: both masters keep requesting reads; last grant was m1
    m0_addr = 16'h0020; m1_addr = 16'h0040;
    m0_ren = 1; m1_ren = 1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rr_owner", 32'(owner), 32'(i % 2));
      chk("rr_s_addr", 32'(s_addr), (i % 2 == 0) ? 32'h0020 : 32'h0040);
      s_rd_valid = 1; s_rdata = 32'h100 + 32'(i);
      #1;
      chk("rr_rdv", {30'd0, m1_rd_valid, m0_rd_valid}, (i % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      s_rd_valid = 0;
      chk("rr_idle", 32'(dbg_state), 32'(ST_IDLE));
    end
    m0_ren = 0; m1_ren = 0;
    tick();

    // Timeout: m1 reads unmapped space, slave never answers
    m1_addr = 16'h6000; m1_ren = 1; s_rdata = 32'hCAFEF00D;
    tick();
    chk("to_owner", 32'(owner), 1);
    chk("to_s_ren", 32'(s_ren), 1);
    for (int k = 1; k < TMO; k++) begin
      tick();
      chk("to_early", {29'd0, bus_err, m1_rd_valid, m0_rd_valid}, 0);
    end
    tick();
    chk("to_m1_rdv", 32'(m1_rd_valid), 1);
    chk("to_m0_rdv", 32'(m0_rd_valid), 0);
    chk("to_rdata", m1_rdata, 0);
    chk("to_bus_err", 32'(bus_err), 1);
    m1_ren = 0;
    tick();
    chk("to_err_drop", 32'(bus_err), 0);
    chk("to_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("to_s_ren_drop", 32'(s_ren), 0);
    s_rdata = '0;

    // Reset during RD_WAIT, then an m1-only request after release
    m1_addr = 16'h0080; m1_ren = 1;
    tick();
    chk("rm_owner", 32'(owner), 1);
    tick();
    rst = 1;
    #1;
    chk("rm_s_ren", 32'(s_ren), 0);
    chk("rm_owner0", 32'(owner), 0);
    chk("rm_rdv", {30'd0, m1_rd_valid, m0_rd_valid}, 0);
    chk("rm_state", 32'(dbg_state), 32'(ST_IDLE));
    tick();
    rst = 0;
    tick();
    chk("rm_regrant_owner", 32'(owner), 1);
    chk("rm_regrant_s_ren", 32'(s_ren), 1);
    s_rd_valid = 1; s_rdata = 32'h0BADF00D;
    #1;
    chk("rm_m1_rdv", 32'(m1_rd_valid), 1);
    chk("rm_m1_rdata", m1_rdata, 32'h0BADF00D);
    m1_ren = 0;
    tick();
    s_rd_valid = 0;

    // ren and wen together from m0 is a read
    m0_addr = 16'h0030; m0_ren = 1; m0_wen = 1; m0_wdata = 32'hFFFF0000;
    tick();
    chk("rw_s_ren", 32'(s_ren), 1);
    chk("rw_s_wen", 32'(s_wen), 0);
    chk("rw_wack", 32'(m0_wack), 0);
    s_rd_valid = 1; s_rdata = 32'h55AA55AA;
    #1;
    chk("rw_rdv", 32'(m0_rd_valid), 1);
    m0_ren = 0; m0_wen = 0;
    tick();
    s_rd_valid = 0;
    chk("rw_s_wen_after", 32'(s_wen), 0);
    chk("rw_idle", 32'(dbg_state), 32'(ST_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arb.md
# bus_arb

Two-master arbiter that shares the single peripheral bus (block RAM, SPRAM, LED, UART decode) between the CPU and a second master such as a DMA engine or debug loader. It sits between the masters and the address decoder. It serialises their read and write transactions with round-robin fairness, registers the slave-side request, and routes responses back to the owning master. A read timeout guarantees forward progress when the decoder selects no slave and `rd_valid` never arrives.

## Interface
- `W`, 32, data width.
- `AW`, 16, address width.
- `TMO`, 15, number of cycles in RD_WAIT without `s_rd_valid` before the read is force-completed (1..255).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `m0_addr`, `m1_addr`  in  AW  master request address.
- `m0_ren`, `m1_ren`  in  1  read request; held until the matching `mN_rd_valid`.
- `m0_wen`, `m1_wen`  in  1  write request; held until the matching `mN_wack`.
- `m0_wdata`, `m1_wdata`  in  W  write data.
- `m0_wmask`, `m1_wmask`  in  4  byte write mask.
- `m0_rdata`, `m1_rdata`  out  W  read data; valid only while the matching `mN_rd_valid` is high.
- `m0_rd_valid`, `m1_rd_valid`  out  1  read completion.
- `m0_wack`, `m1_wack`  out  1  write accepted; one-cycle pulse.
- `s_addr`  out  AW  registered slave address.
- `s_ren`, `s_wen`  out  1  registered slave strobes.
- `s_wdata`  out  W  registered write data.
- `s_wmask`  out  4  registered write mask.
- `s_rdata`  in  W  slave read data.
- `s_rd_valid`  in  1  slave read completion.
- `owner`  out  1  index of the current or last granted master.
- `bus_err`  out  1  one-cycle pulse on read timeout.

## Operation
- A master requests when `mN_ren | mN_wen`. If both are high, the request is a read and `wen` is ignored.
- States are IDLE, WR_ISSUE and RD_WAIT.
- **IDLE**, no request: stay in IDLE; all strobes low.
- **IDLE**, one or more requests: pick a winner by round-robin.
  - A lone requester always wins.
  - On a tie, the master not granted last wins.
  - On the same edge: latch the winner's addr/wdata/wmask into `s_*`, set `owner`, and update the last-granted index.
- **Write grant**: go to WR_ISSUE with `s_wen`=1 and `mOwner_wack`=1, both registered.
- **WR_ISSUE**: lasts exactly one cycle, then return to IDLE and drop `s_wen` and `wack`. No request is sampled in this state.
- **Read grant**: go to RD_WAIT with `s_ren`=1 and the timeout counter cleared.
- **RD_WAIT** behaviour:
  - `s_ren` stays high.
  - `mOwner_rd_valid` = `s_rd_valid` (combinational).
  - Both `mN_rdata` = `s_rdata`.
  - On an edge with `s_rd_valid`=1: drop `s_ren` and go to IDLE.
  - Otherwise the counter increments. When counter == `TMO`, the arbiter drives `mOwner_rd_valid`=1 and `mN_rdata`=0 for that cycle and pulses `bus_err`, then goes to IDLE.
- The non-owner's `rd_valid` and `wack` are always 0.
- A master dropping its request mid-transaction is illegal. The arbiter does not abort and completes the transaction anyway.

## Timing
- **Reset values**: state IDLE, all `s_*` = 0, all `mN_rd_valid`/`mN_wack` = 0, `bus_err` = 0, `owner` = 0, last-granted = 1 (m0 wins the first tie). `rdata` outputs are 0 outside RD_WAIT.
- **Reset mid-transaction**: the in-flight transaction is abandoned with no `wack` or `rd_valid`, and `s_ren`/`s_wen` fall immediately.
- **Write**: the request is sampled at edge E; `s_wen` and `wack` are high for the cycle E..E+1; the next request is sampled at E+2. Throughput is 1 write per 2 cycles.
- **Read**: the request is sampled at edge E; `s_ren` is high from E onward.
  - With a 1-cycle slave (`s_rd_valid` in the cycle after E), `rd_valid` reaches the master in cycle E..E+1.
  - State returns to IDLE at E+1, and the next grant is at E+2 at the earliest.
- **Timeout**: `rd_valid`/`bus_err` are asserted in the cycle in which the counter equals `TMO`, i.e. `TMO`+1 cycles after the grant edge.
- **Counter**: 8 bits wide; it never wraps because `TMO` ≤ 255.
- `s_rd_valid` arriving in IDLE or WR_ISSUE is ignored.

## Structure
- **Package `bus_pkg`** holds:
  - the state encoding (IDLE/WR_ISSUE/RD_WAIT);
  - the default `TMO`;
  - bus address/data width constants shared with the decoder and peripherals.
- **Sub-module `rr_arb2`**: combinational pick from (`req[1:0]`, last-granted), returning the winner index. Everything else lives in `bus_arb`.

## Test plan
- **Lone read**: m0 read at 0x0010 with a 1-cycle slave returning 0xDEADBEEF -> `s_ren` for 1 cycle after the grant; `m0_rd_valid` with rdata 0xDEADBEEF; m1 outputs stay 0.
- **Simultaneous writes**: m0 and m1 write at the same edge after reset -> m0 is granted first (`wack` at E..E+1), m1 second (`wack` at E+2..E+3); `s_wdata`/`s_wmask` match each master.
- **Round-robin**: both masters continuously requesting reads -> grants alternate 0,1,0,1 over 8 transactions; `owner` tracks each grant.
- **Timeout**: m1 read to unmapped 0x6000 with `s_rd_valid` held low, `TMO`=15 -> `m1_rd_valid`=1, rdata=0 and `bus_err` pulse 16 cycles after the grant; state returns to IDLE.
- **Reset mid-read**: assert `rst` during RD_WAIT -> `s_ren` and `owner` go to 0 and no `rd_valid` is issued; after release, an m1-only request is granted normally.
- **Read+write conflict**: m0 asserts `ren` and `wen` together -> treated as a read; `s_wen` is never asserted.
